// File: rtl/alu_seq_checker_if.sv
// alu_seq_checker_if: configuration, ALU drive and status bundle between the self-test checker and its environment
interface alu_seq_checker_if #(
  parameter int NB_DATA = 16,
  parameter int NB_CNT  = 8
);
  logic               i_start;
  logic [NB_CNT-1:0]  i_num_vec;
  logic [NB_DATA-1:0] i_base_a;
  logic [NB_DATA-1:0] i_base_b;
  logic [NB_DATA-1:0] i_step;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] o_dataA;
  logic [NB_DATA-1:0] o_dataB;
  logic [1:0]         o_sel;
  logic               o_busy;
  logic               o_done;
  logic               o_pass;
  logic [NB_CNT-1:0]  o_err_cnt;
  logic [NB_CNT-1:0]  o_first_err_idx;
  modport master (
    input  i_start, i_num_vec, i_base_a, i_base_b, i_step, i_result,
    output o_dataA, o_dataB, o_sel, o_busy, o_done, o_pass, o_err_cnt, o_first_err_idx
  );
  modport slave (
    output i_start, i_num_vec, i_base_a, i_base_b, i_step, i_result,
    input  o_dataA, o_dataB, o_sel, o_busy, o_done, o_pass, o_err_cnt, o_first_err_idx
  );
endinterface

// File: rtl/alu_seq_checker.sv
// alu_seq_checker: on-chip self-test that drives arithmetic-progression vectors into the registered ALU and scores its results
module alu_seq_checker #(
  parameter int NB_DATA = 16,
  parameter int NB_CNT  = 8,
  parameter int ALU_LAT = 1
) (
  input logic              clock,
  input logic              i_reset,
  alu_seq_checker_if.master bus
);
  localparam int NB_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;
  state_t             state, nextState;
  logic [NB_CNT-1:0]  numVec, idx;
  logic [NB_DATA-1:0] stepReg, accA, accB, expected, opResult;
  logic [NB_W-1:0]    waitCnt;
  logic               lastVec;
  assign lastVec = idx == numVec - NB_CNT'(1);
  always_comb begin
    opResult = idx[1] ? (idx[0] ? (accA | accB) : (accA & accB))
                      : (idx[0] ? (accA - accB) : (accA + accB));
  end
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (bus.i_start) nextState = (bus.i_num_vec == '0) ? DONE : ISSUE;
      ISSUE: nextState = WAIT;
      WAIT:  if (waitCnt == '0) nextState = CHECK;
      CHECK: nextState = lastVec ? DONE : ISSUE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  // Accumulators hold A_k/B_k for the current index, so no multiplier is needed
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      numVec              <= '0;
      idx                 <= '0;
      stepReg             <= '0;
      accA                <= '0;
      accB                <= '0;
      expected            <= '0;
      waitCnt             <= '0;
      bus.o_dataA         <= '0;
      bus.o_dataB         <= '0;
      bus.o_sel           <= '0;
      bus.o_busy          <= 1'b0;
      bus.o_done          <= 1'b0;
      bus.o_pass          <= 1'b0;
      bus.o_err_cnt       <= '0;
      bus.o_first_err_idx <= '1;
    end else begin
      bus.o_done <= 1'b0;
      unique case (state)
        IDLE: if (bus.i_start) begin
          numVec              <= bus.i_num_vec;
          stepReg             <= bus.i_step;
          accA                <= bus.i_base_a;
          accB                <= bus.i_base_b;
          idx                 <= '0;
          bus.o_err_cnt       <= '0;
          bus.o_first_err_idx <= '1;
          bus.o_pass          <= 1'b0;
          bus.o_busy          <= 1'b1;
        end
        ISSUE: begin
          bus.o_dataA <= accA;
          bus.o_dataB <= accB;
          bus.o_sel   <= idx[1:0];
          expected    <= opResult;
          waitCnt     <= NB_W'(ALU_LAT - 1);
        end
        WAIT: if (waitCnt != '0) waitCnt <= waitCnt - NB_W'(1);
        CHECK: begin
          if (bus.i_result != expected) begin
            bus.o_err_cnt <= bus.o_err_cnt + NB_CNT'(1);
            if (bus.o_err_cnt == '0) bus.o_first_err_idx <= idx;
          end
          if (!lastVec) begin
            idx  <= idx + NB_CNT'(1);
            accA <= accA + stepReg;
            accB <= accB - stepReg;
          end
        end
        DONE: begin
          bus.o_done <= 1'b1;
          bus.o_busy <= 1'b0;
          bus.o_pass <= bus.o_err_cnt == '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_checker.sv
// tb_alu_seq_checker: directed and randomized runs of the checker against a behavioural ALU stub and reference model
module tb_alu_seq_checker;
  logic clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 clock = ~clock;
  alu_seq_checker_if #(.NB_DATA(16), .NB_CNT(8)) bus ();
  alu_seq_checker #(.NB_DATA(16), .NB_CNT(8), .ALU_LAT(1)) dut (
    .clock(clock),
    .i_reset(i_reset),
    .bus(bus.master)
  );
  int compared = 0;
  int mismatched = 0;
  int doneCnt = 0;
  int faultMode = 0;
  logic [1:0]  faultSel = 2'd0;
  logic [15:0] faultMask = 16'd0;
  logic [15:0] lastA = 16'd0;
  logic [15:0] lastB = 16'd0;
  logic [1:0]  lastSel = 2'd0;

  function automatic logic [15:0] refOp(logic [15:0] a, logic [15:0] b, int sel);
    case (sel)
      0: return 16'(a + b);
      1: return 16'(a - b);
      2: return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [15:0] aluStub(logic [15:0] a, logic [15:0] b, logic [1:0] sel);
    if (faultMode == 1 && sel == 2'd1) return 16'h0001;
    if (faultMode == 2 && sel == faultSel) return refOp(a, b, int'(sel)) ^ faultMask;
    return refOp(a, b, int'(sel));
  endfunction

  always @(posedge clock) bus.i_result <= aluStub(bus.o_dataA, bus.o_dataB, bus.o_sel);
  always @(posedge clock) if (bus.o_done === 1'b1) doneCnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, input logic [15:0] a0, input logic [15:0] b0,
                     input logic [15:0] st, input int mode, input bit pulseMid);
    logic [15:0] av[256];
    logic [15:0] bv[256];
    int err = 0;
    int first = 255;
    int d0;
    faultMode = mode;
    for (int k = 0; k < n; k++) begin
      av[k] = 16'(a0 + st * 16'(k));
      bv[k] = 16'(b0 - st * 16'(k));
      if (aluStub(av[k], bv[k], 2'(k)) !== refOp(av[k], bv[k], k % 4)) begin
        if (err == 0) first = k;
        err++;
      end
    end
    @(negedge clock);
    bus.i_num_vec = 8'(n);
    bus.i_base_a = a0;
    bus.i_base_b = b0;
    bus.i_step = st;
    bus.i_start = 1'b1;
    d0 = doneCnt;
    @(posedge clock);
    #1 bus.i_start = 1'b0;
    bus.i_base_a = ~a0;
    bus.i_step = st + 16'd3;
    check("busy_after_start", 32'(bus.o_busy), 1);
    for (int c = 1; c <= 3 * n + 2; c++) begin
      @(posedge clock);
      #1;
      if (pulseMid && c == 4) bus.i_start = 1'b1;
      if (c == 5) bus.i_start = 1'b0;
      if (c % 3 == 1 && c < 3 * n + 1) begin
        check("dataA", 32'(bus.o_dataA), 32'(av[c / 3]));
        check("dataB", 32'(bus.o_dataB), 32'(bv[c / 3]));
        check("sel", 32'(bus.o_sel), 32'((c / 3) % 4));
      end
      if (c == 3 * n && n > 0) check("done_early", 32'(bus.o_done), 0);
      if (c == 3 * n + 1) begin
        check("done_pulse", 32'(bus.o_done), 1);
        check("busy_at_done", 32'(bus.o_busy), 0);
        check("pass", 32'(bus.o_pass), (err == 0) ? 1 : 0);
        check("err_cnt", 32'(bus.o_err_cnt), 32'(err));
        check("first_idx", 32'(bus.o_first_err_idx), 32'(first));
        if (n == 0) begin
          check("held_dataA", 32'(bus.o_dataA), 32'(lastA));
          check("held_dataB", 32'(bus.o_dataB), 32'(lastB));
          check("held_sel", 32'(bus.o_sel), 32'(lastSel));
        end
      end
      if (c == 3 * n + 2) begin
        check("done_cleared", 32'(bus.o_done), 0);
        check("pass_held", 32'(bus.o_pass), (err == 0) ? 1 : 0);
      end
    end
    check("done_count", 32'(doneCnt), 32'(d0 + 1));
    if (n > 0) begin
      lastA = av[n - 1];
      lastB = bv[n - 1];
      lastSel = 2'(n - 1);
    end
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_dataA"}, 32'(bus.o_dataA), 0);
    check({tag, "_dataB"}, 32'(bus.o_dataB), 0);
    check({tag, "_sel"}, 32'(bus.o_sel), 0);
    check({tag, "_busy"}, 32'(bus.o_busy), 0);
    check({tag, "_done"}, 32'(bus.o_done), 0);
    check({tag, "_pass"}, 32'(bus.o_pass), 0);
    check({tag, "_err"}, 32'(bus.o_err_cnt), 0);
    check({tag, "_first"}, 32'(bus.o_first_err_idx), 32'hFF);
  endtask

  initial begin
    int d0;
    bus.i_start = 1'b0;
    bus.i_num_vec = 8'd0;
    bus.i_base_a = 16'd0;
    bus.i_base_b = 16'd0;
    bus.i_step = 16'd0;
    repeat (3) @(posedge clock);
    #1 checkResetValues("reset");
    @(negedge clock);
    i_reset = 1'b0;
    repeat (2) @(posedge clock);
    run(4, 16'hFFF1, 16'hFFF1, 16'h0000, 0, 1'b0);
    run(4, 16'hFFF1, 16'hFFF1, 16'h0000, 1, 1'b0);
    run(2, 16'h7FFF, 16'h0001, 16'h0001, 0, 1'b0);
    run(0, 16'h1234, 16'h5678, 16'h0001, 0, 1'b0);
    run(4, 16'h0100, 16'h0020, 16'h0011, 0, 1'b1);
    @(negedge clock);
    faultMode = 0;
    bus.i_num_vec = 8'd4;
    bus.i_base_a = 16'hFFF1;
    bus.i_base_b = 16'hFFF1;
    bus.i_step = 16'd0;
    bus.i_start = 1'b1;
    d0 = doneCnt;
    @(posedge clock);
    #1 bus.i_start = 1'b0;
    repeat (8) @(posedge clock);
    #2 i_reset = 1'b1;
    #1 checkResetValues("abort");
    repeat (2) @(negedge clock);
    i_reset = 1'b0;
    repeat (15) @(posedge clock);
    #1 check("no_done_after_abort", 32'(doneCnt), 32'(d0));
    check("idle_after_abort", 32'(bus.o_busy), 0);
    lastA = 16'd0;
    lastB = 16'd0;
    lastSel = 2'd0;
    run(4, 16'hFFF1, 16'hFFF1, 16'h0000, 0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      faultSel = 2'($urandom_range(0, 3));
      faultMask = 16'($urandom_range(1, 65535));
      run($urandom_range(1, 10), 16'($urandom), 16'($urandom), 16'($urandom),
          (r % 2 == 0) ? 0 : 2, 1'($urandom_range(0, 1)));
    end
    run(0, 16'hAAAA, 16'h5555, 16'h0007, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
